// File: rtl/button_conditioner.sv
// Multi-channel pin conditioner: synchroniser chain, polarity normalisation,
// per-channel debounce counter, registered level plus rise/fall strobes.
module button_conditioner #(
    parameter int                  CHANNELS        = 5,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 250000,
    parameter logic [CHANNELS-1:0] INVERT          = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                debounce_en,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s;
    logic [CW-1:0]       cnt_q  [CHANNELS];
    logic [CW-1:0]       cnt_d  [CHANNELS];
    logic [CHANNELS-1:0] level_d;

    // Sync flops reset to the idle pin level so no false edge follows reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++)
                sync_q[k] <= INVERT;
        end else begin
            sync_q[0] <= raw_in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++)
                sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ INVERT;

    always_comb begin
        level_d = level;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            if (!debounce_en) begin
                level_d[i] = s[i];
            end else if (s[i] != level[i]) begin
                if (cnt_q[i] == CNT_LAST)
                    level_d[i] = s[i];
                else
                    cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= '0;
            rise  <= '0;
            fall  <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++)
                cnt_q[i] <= '0;
        end else begin
            level <= level_d;
            rise  <= level_d & ~level;
            fall  <= ~level_d & level;
            for (int unsigned i = 0; i < CHANNELS; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus pushes model expectations,
// a monitor pops and compares one entry per clock edge.
module tb_button_conditioner;

    localparam int         CH  = 4;
    localparam int         SS  = 2;
    localparam int         DC  = 8;
    localparam logic [3:0] INV = 4'b0011;

    logic       clk = 1'b1;
    logic       reset = 1'b0;
    logic       debounce_en = 1'b1;
    logic [3:0] raw_in = INV;
    logic [3:0] level, rise, fall;

    always #5 clk = ~clk;

    button_conditioner #(
        .CHANNELS(CH),
        .SYNC_STAGES(SS),
        .DEBOUNCE_CYCLES(DC),
        .INVERT(INV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .debounce_en(debounce_en),
        .raw_in(raw_in),
        .level(level),
        .rise(rise),
        .fall(fall)
    );

    typedef struct packed {
        logic [3:0] lv;
        logic [3:0] rs;
        logic [3:0] fl;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   stim_done = 0;

    // Reference: s is the raw pin DC-independent delayed by SS edges; level
    // adopts s when the last DC samples of s all disagreed with level.
    logic [3:0] m_raw[$];
    logic [3:0] m_s[$];
    logic [3:0] m_level = '0;

    function automatic exp_t model_edge(input logic [3:0] raw, input logic en, input logic rst);
        exp_t       e;
        logic [3:0] sv;
        logic [3:0] nl;
        int         n;
        bit         all_diff;
        e = '0;
        if (rst) begin
            m_raw.delete();
            m_s.delete();
            m_level = '0;
            return e;
        end
        m_raw.push_back(raw);
        n  = m_raw.size();
        sv = (n > SS) ? (m_raw[n-1-SS] ^ INV) : 4'b0000;
        m_s.push_back(sv);
        nl = m_level;
        for (int c = 0; c < CH; c++) begin
            if (!en) begin
                nl[c] = sv[c];
            end else if (n >= DC) begin
                all_diff = 1;
                for (int k = n - DC; k < n; k++)
                    if (m_s[k][c] == m_level[c]) all_diff = 0;
                if (all_diff) nl[c] = sv[c];
            end
        end
        e.lv = nl;
        e.rs = nl & ~m_level;
        e.fl = ~nl & m_level;
        m_level = nl;
        return e;
    endfunction

    task automatic step(input logic [3:0] raw, input logic en, input logic rst);
        @(negedge clk);
        raw_in      = raw;
        debounce_en = en;
        if (rst) begin
            if (!reset) begin
                #1 reset = 1'b1;
                #1;
                total++;
                if ({level, rise, fall} != 12'h000) begin
                    bad++;
                    $display("FAIL reset_async: got level=%b rise=%b fall=%b want all 0",
                             level, rise, fall);
                end
            end
        end else begin
            reset = 1'b0;
        end
        exp_q.push_back(model_edge(raw, en, rst));
    endtask

    task automatic hold(input logic [3:0] raw, input logic en, input int n);
        repeat (n) step(raw, en, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                if (!stim_done) begin
                    total++;
                    bad++;
                    $display("FAIL no_expectation: got level=%b want a queued entry", level);
                end
            end else begin
                e = exp_q.pop_front();
                total++;
                if (level !== e.lv) begin
                    bad++;
                    $display("FAIL level @%0t: got %b want %b", $time, level, e.lv);
                end
                total++;
                if (rise !== e.rs) begin
                    bad++;
                    $display("FAIL rise @%0t: got %b want %b", $time, rise, e.rs);
                end
                total++;
                if (fall !== e.fl) begin
                    bad++;
                    $display("FAIL fall @%0t: got %b want %b", $time, fall, e.fl);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL timeout: got no end of stimulus want finish before 400000");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin : stimulus
        logic [3:0] r;
        logic       en;
        int         len;
        // reset asserted between edges, then idle
        step(INV, 1'b1, 1'b1);
        step(INV, 1'b1, 1'b1);
        hold(INV, 1'b1, 20);
        // clean press and release on ch2
        hold(INV | 4'b0100, 1'b1, 14);
        hold(INV, 1'b1, 14);
        // glitch one cycle short of qualifying
        hold(INV | 4'b0100, 1'b1, 7);
        hold(INV, 1'b1, 1);
        hold(INV | 4'b0100, 1'b1, 14);
        hold(INV, 1'b1, 14);
        // active-low ch0
        hold(4'b0010, 1'b1, 14);
        hold(INV, 1'b1, 14);
        // bypass: one-cycle pulse on ch3
        hold(INV, 1'b0, 3);
        step(INV | 4'b1000, 1'b0, 1'b0);
        hold(INV, 1'b0, 6);
        hold(INV, 1'b1, 3);
        // simultaneous channels, then again with reset mid-count
        hold(INV | 4'b0110, 1'b1, 14);
        hold(INV, 1'b1, 14);
        hold(INV | 4'b0110, 1'b1, 5);
        step(INV | 4'b0110, 1'b1, 1'b1);
        hold(INV | 4'b0110, 1'b1, 14);
        hold(INV, 1'b1, 14);
        // randomized holds, glitches, bypass toggles and resets
        for (int i = 0; i < 200; i++) begin
            r   = 4'($urandom);
            len = $urandom_range(1, 14);
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 39) == 0) step(r, en, 1'b1);
            hold(r, en, len);
        end
        @(posedge clk);
        #2;
        stim_done = 1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
